// File: rtl/ps2_poll_ctrl_if.sv
// Byte-level handshake between the PS2 poll controller and its SPI byte driver.
// Signal names are seen from the controller side.
interface ps2_poll_ctrl_if;
  logic       o_send_req;
  logic [7:0] o_send_data;
  logic       i_send_busy;
  logic [7:0] i_recv_data;
  logic       i_recv_valid;
  logic       i_spi_done;

  modport master (
    output o_send_req, o_send_data,
    input  i_send_busy, i_recv_data, i_recv_valid, i_spi_done
  );

  modport slave (
    input  o_send_req, o_send_data,
    output i_send_busy, i_recv_data, i_recv_valid, i_spi_done
  );
endinterface

// File: rtl/ps2_poll_ctrl.sv
// Periodically polls a PS2 (DualShock-style) controller with a 9-byte SPI frame,
// validates the reply and publishes buttons, stick axes and mode.
module ps2_poll_ctrl #(
  parameter int CLK_FRE     = 50,
  parameter int POLL_HZ     = 60,
  parameter int GAP_CYC     = 800,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic            i_sys_clk,
  input  logic            i_rst_n,
  input  logic            i_enable,
  ps2_poll_ctrl_if.master spi,
  output logic [15:0]     o_buttons,
  output logic [7:0]      o_rx,
  output logic [7:0]      o_ry,
  output logic [7:0]      o_lx,
  output logic [7:0]      o_ly,
  output logic [7:0]      o_mode_id,
  output logic            o_data_valid,
  output logic            o_frame_err
);
  localparam int POLL_CNT = CLK_FRE * 1000000 / POLL_HZ;
  localparam int PW = (POLL_CNT > 1) ? $clog2(POLL_CNT) : 1;
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_GAP   = 3'd3,
    ST_CHECK = 3'd4
  } state_t;

  state_t        state_r, state_nxt_s;
  logic [PW-1:0] poll_cnt_r;
  logic [GW-1:0] gap_cnt_r;
  logic [TW-1:0] tmo_cnt_r;
  logic [3:0]    idx_r;
  logic [7:0]    frame_buf_r [0:8];
  logic          send_req_r, data_valid_r, frame_err_r;
  logic [7:0]    send_data_r, mode_r, rx_r, ry_r, lx_r, ly_r;
  logic [15:0]   buttons_r;
  logic          poll_tick_s, send_fire_s, store_s, timeout_s, check_s, frame_good_s;

  function automatic logic [7:0] cmd_byte(input logic [3:0] idx);
    case (idx)
      4'd0:    cmd_byte = 8'h01;
      4'd1:    cmd_byte = 8'h42;
      default: cmd_byte = 8'h00;
    endcase
  endfunction

  assign poll_tick_s  = (poll_cnt_r == PW'(POLL_CNT - 1));
  assign frame_good_s = ((frame_buf_r[1] == 8'h41) || (frame_buf_r[1] == 8'h73)) &&
                        (frame_buf_r[2] == 8'h5A);

  // State register
  always_ff @(posedge i_sys_clk) begin
    if (!i_rst_n) state_r <= ST_IDLE;
    else          state_r <= state_nxt_s;
  end

  // Next-state decode and per-cycle control strobes
  always_comb begin
    state_nxt_s = state_r;
    send_fire_s = 1'b0;
    store_s     = 1'b0;
    timeout_s   = 1'b0;
    check_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (poll_tick_s && i_enable) state_nxt_s = ST_REQ;
        else                         state_nxt_s = ST_IDLE;
      end
      ST_REQ: begin
        if (!spi.i_send_busy) begin
          send_fire_s = 1'b1;
          state_nxt_s = ST_WAIT;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (spi.i_spi_done && spi.i_recv_valid) begin
          store_s = 1'b1;
          if (idx_r == 4'd8) state_nxt_s = ST_CHECK;
          else               state_nxt_s = ST_GAP;
        end else if (tmo_cnt_r == TW'(TIMEOUT_CYC - 1)) begin
          timeout_s   = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_GAP: begin
        if (gap_cnt_r == GW'(GAP_CYC - 1)) state_nxt_s = ST_REQ;
        else                               state_nxt_s = ST_GAP;
      end
      ST_CHECK: begin
        check_s     = 1'b1;
        state_nxt_s = ST_IDLE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Counters, frame buffer and registered outputs; poll counter free-runs in every state
  always_ff @(posedge i_sys_clk) begin
    if (!i_rst_n) begin
      poll_cnt_r   <= '0;
      gap_cnt_r    <= '0;
      tmo_cnt_r    <= '0;
      idx_r        <= 4'd0;
      for (int i = 0; i < 9; i++) frame_buf_r[i] <= 8'h00;
      send_req_r   <= 1'b0;
      send_data_r  <= 8'h00;
      buttons_r    <= 16'h0000;
      rx_r         <= 8'h80;
      ry_r         <= 8'h80;
      lx_r         <= 8'h80;
      ly_r         <= 8'h80;
      mode_r       <= 8'h00;
      data_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      poll_cnt_r   <= poll_tick_s ? '0 : poll_cnt_r + PW'(1);
      gap_cnt_r    <= (state_r == ST_GAP) ? gap_cnt_r + GW'(1) : '0;
      tmo_cnt_r    <= (state_r == ST_WAIT) ? tmo_cnt_r + TW'(1) : '0;
      send_req_r   <= send_fire_s;
      data_valid_r <= check_s & frame_good_s;
      frame_err_r  <= timeout_s | (check_s & ~frame_good_s);
      if (send_fire_s) send_data_r <= cmd_byte(idx_r);
      if (state_r == ST_IDLE) idx_r <= 4'd0;
      else if (store_s)       idx_r <= idx_r + 4'd1;
      if (timeout_s) begin
        for (int i = 0; i < 9; i++) frame_buf_r[i] <= 8'h00;
      end else if (store_s) begin
        frame_buf_r[idx_r] <= spi.i_recv_data;
      end
      // Digital-mode frames carry no stick bytes, so axes report centre
      if (check_s && frame_good_s) begin
        buttons_r <= ~{frame_buf_r[4], frame_buf_r[3]};
        mode_r    <= frame_buf_r[1];
        if (frame_buf_r[1] == 8'h73) begin
          rx_r <= frame_buf_r[5];
          ry_r <= frame_buf_r[6];
          lx_r <= frame_buf_r[7];
          ly_r <= frame_buf_r[8];
        end else begin
          rx_r <= 8'h80;
          ry_r <= 8'h80;
          lx_r <= 8'h80;
          ly_r <= 8'h80;
        end
      end
    end
  end

  assign spi.o_send_req  = send_req_r;
  assign spi.o_send_data = send_data_r;
  assign o_buttons       = buttons_r;
  assign o_rx            = rx_r;
  assign o_ry            = ry_r;
  assign o_lx            = lx_r;
  assign o_ly            = ly_r;
  assign o_mode_id       = mode_r;
  assign o_data_valid    = data_valid_r;
  assign o_frame_err     = frame_err_r;
endmodule

// File: tb/tb_ps2_poll_ctrl.sv
// Self-checking bench: a reactive SPI byte-driver model plus a frame-level
// reference model of the expected controller outputs.
module tb_ps2_poll_ctrl;
  localparam int CLK_FRE     = 1;
  localparam int POLL_HZ     = 2000;
  localparam int POLL_CNT    = CLK_FRE * 1000000 / POLL_HZ;
  localparam int GAP_CYC     = 8;
  localparam int TIMEOUT_CYC = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [15:0] buttons;
  logic [7:0]  rx, ry, lx, ly, mode_id;
  logic        data_valid, frame_err;

  ps2_poll_ctrl_if bus ();

  ps2_poll_ctrl #(
    .CLK_FRE(CLK_FRE), .POLL_HZ(POLL_HZ), .GAP_CYC(GAP_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .i_sys_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .spi(bus.master),
    .o_buttons(buttons), .o_rx(rx), .o_ry(ry), .o_lx(lx), .o_ly(ly),
    .o_mode_id(mode_id), .o_data_valid(data_valid), .o_frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Driver model state
  logic [7:0] reply [9];
  bit         drv_silent = 1'b0;
  int         frame_base = 0;
  int         spur_req_cnt = 0;
  int         spur_done_cnt = 0;
  logic [7:0] cmd_log [$];
  int         req_cyc_q [$];

  // Monitor state
  int dv_cnt = 0, err_cnt = 0, wide_cnt = 0, overlap_cnt = 0, last_err_cyc = 0;
  bit prev_req = 1'b0;

  // Reference model outputs
  logic [15:0] exp_btn;
  logic [7:0]  exp_rx, exp_ry, exp_lx, exp_ly, exp_mode;
  int          prev_first = 0;

  initial begin : driver
    int idx, lat, hold;
    logic [7:0] data;
    bus.i_send_busy  = 1'b0;
    bus.i_recv_data  = 8'h00;
    bus.i_recv_valid = 1'b0;
    bus.i_spi_done   = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (bus.o_send_req === 1'b1) begin
        cmd_log.push_back(bus.o_send_data);
        req_cyc_q.push_back(cyc);
        idx  = cmd_log.size() - 1 - frame_base;
        data = (idx >= 0 && idx < 9) ? reply[idx] : 8'h00;
        if (!drv_silent) begin
          lat  = $urandom_range(1, 4);
          hold = $urandom_range(0, 12);
          bus.i_send_busy = 1'b1;
          repeat (lat) begin @(posedge clk); #1; end
          bus.i_recv_data  = data;
          bus.i_recv_valid = 1'b1;
          bus.i_spi_done   = 1'b1;
          bus.i_send_busy  = (hold != 0);
          @(posedge clk); #1;
          bus.i_recv_valid = 1'b0;
          bus.i_spi_done   = 1'b0;
          repeat (hold) begin @(posedge clk); #1; end
          bus.i_send_busy = 1'b0;
        end
      end else if (spur_req_cnt != spur_done_cnt) begin
        bus.i_recv_data  = 8'hA5;
        bus.i_recv_valid = 1'b1;
        bus.i_spi_done   = 1'b1;
        @(posedge clk); #1;
        bus.i_recv_valid = 1'b0;
        bus.i_spi_done   = 1'b0;
        spur_done_cnt++;
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (bus.o_send_req === 1'b1 && prev_req) wide_cnt++;
      prev_req = (bus.o_send_req === 1'b1);
      if (data_valid === 1'b1 && frame_err === 1'b1) overlap_cnt++;
      if (data_valid === 1'b1) dv_cnt++;
      if (frame_err === 1'b1) begin err_cnt++; last_err_cyc = cyc; end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, "_buttons"}, {16'h0000, buttons}, {16'h0000, exp_btn});
    chk({tag, "_axes"}, {rx, ry, lx, ly}, {exp_rx, exp_ry, exp_lx, exp_ly});
    chk({tag, "_mode"}, {24'h0, mode_id}, {24'h0, exp_mode});
  endtask

  task automatic model_reset();
    exp_btn = 16'h0000;
    exp_rx = 8'h80; exp_ry = 8'h80; exp_lx = 8'h80; exp_ly = 8'h80;
    exp_mode = 8'h00;
  endtask

  task automatic set_reply(input logic [71:0] bytes);
    for (int i = 0; i < 9; i++) reply[i] = bytes[71 - 8*i -: 8];
  endtask

  // Run one poll frame and score it against the reference model
  task automatic do_frame(input string tag, input bit silent, input bit chk_period,
                          input bit drop_en);
    bit exp_good, got_dv, got_er;
    int d0, e0, nreq;
    drv_silent = silent;
    frame_base = cmd_log.size();
    d0 = dv_cnt; e0 = err_cnt;
    exp_good = !silent && ((reply[1] == 8'h41) || (reply[1] == 8'h73)) && (reply[2] == 8'h5A);
    got_dv = 1'b0; got_er = 1'b0;
    for (int i = 0; i < 3 * POLL_CNT && !got_dv && !got_er; i++) begin
      @(posedge clk); #2;
      if (drop_en && cmd_log.size() > frame_base) enable = 1'b0;
      got_dv = (dv_cnt != d0);
      got_er = (err_cnt != e0);
    end
    chk({tag, "_finished"}, {31'h0, got_dv || got_er}, 32'd1);
    chk({tag, "_data_valid"}, {31'h0, got_dv}, {31'h0, exp_good});
    chk({tag, "_frame_err"}, {31'h0, got_er}, {31'h0, !exp_good});
    if (exp_good) begin
      exp_btn  = ~{reply[4], reply[3]};
      exp_mode = reply[1];
      if (reply[1] == 8'h73) begin
        exp_rx = reply[5]; exp_ry = reply[6]; exp_lx = reply[7]; exp_ly = reply[8];
      end else begin
        exp_rx = 8'h80; exp_ry = 8'h80; exp_lx = 8'h80; exp_ly = 8'h80;
      end
    end
    chk_outputs(tag);
    nreq = cmd_log.size() - frame_base;
    if (silent) begin
      chk({tag, "_req_count"}, nreq, 32'd1);
      if (nreq > 0) chk({tag, "_timeout_cycles"}, last_err_cyc - req_cyc_q[frame_base], TIMEOUT_CYC);
    end else begin
      chk({tag, "_req_count"}, nreq, 32'd9);
      for (int i = 0; i < nreq && i < 9; i++) begin
        chk($sformatf("%s_cmd%0d", tag, i), {24'h0, cmd_log[frame_base + i]},
            (i == 0) ? 32'h01 : (i == 1) ? 32'h42 : 32'h00);
        if (i > 0)
          chk($sformatf("%s_gap%0d", tag, i),
              {31'h0, (req_cyc_q[frame_base + i] - req_cyc_q[frame_base + i - 1]) >= GAP_CYC}, 32'd1);
      end
    end
    if (nreq > 0) begin
      if (chk_period) chk({tag, "_period"}, req_cyc_q[frame_base] - prev_first, POLL_CNT);
      prev_first = req_cyc_q[frame_base];
    end
    repeat (3) @(posedge clk);
    #2;
    chk({tag, "_one_pulse"}, (dv_cnt - d0) + (err_cnt - e0), 32'd1);
    drv_silent = 1'b0;
  endtask

  initial begin : stimulus
    int rel_cyc, base, d0, e0;
    rst_n  = 1'b0;
    enable = 1'b0;
    for (int i = 0; i < 9; i++) reply[i] = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_send_req", {31'h0, bus.o_send_req}, 32'd0);
    chk("reset_send_data", {24'h0, bus.o_send_data}, 32'h00);
    chk("reset_pulses", {30'h0, data_valid, frame_err}, 32'd0);
    chk_outputs("reset");
    rst_n  = 1'b1;
    enable = 1'b1;

    set_reply(72'hFF_73_5A_FE_FF_11_22_33_44);
    do_frame("analog", 1'b0, 1'b0, 1'b0);
    set_reply({8'hFF, 8'h41, 8'h5A, 8'hFF, 8'h7F, 32'h9ABCDEF0});
    do_frame("digital", 1'b0, 1'b1, 1'b0);
    set_reply(72'hFF_73_00_00_00_55_66_77_88);
    do_frame("bad_id", 1'b0, 1'b1, 1'b0);

    // Stray completion strobe while idle must be ignored
    d0 = dv_cnt; e0 = err_cnt;
    spur_req_cnt++;
    repeat (10) @(posedge clk);
    #2;
    chk("spurious_done", (dv_cnt - d0) + (err_cnt - e0), 32'd0);
    set_reply(72'hFF_73_5A_FE_FF_11_22_33_44);
    do_frame("after_spur", 1'b0, 1'b0, 1'b0);

    do_frame("timeout", 1'b1, 1'b1, 1'b0);
    set_reply(72'hFF_73_5A_00_F0_01_02_03_04);
    do_frame("after_tmo", 1'b0, 1'b1, 1'b0);

    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 9; i++) reply[i] = 8'($urandom);
      case ($urandom_range(0, 3))
        0:       reply[1] = 8'h41;
        1, 2:    reply[1] = 8'h73;
        default: reply[1] = reply[1];
      endcase
      if ($urandom_range(0, 3) != 0) reply[2] = 8'h5A;
      do_frame($sformatf("rand%0d", k), 1'b0, 1'b1, 1'b0);
    end

    // Dropping enable mid-frame lets the frame finish, then stops polling
    set_reply(72'hFF_73_5A_3C_C3_AA_BB_CC_DD);
    do_frame("en_drop", 1'b0, 1'b1, 1'b1);
    base = frame_base;
    repeat (2 * POLL_CNT) @(posedge clk);
    #2;
    chk("disabled_no_req", cmd_log.size() - base, 32'd9);
    enable = 1'b1;

    // Reset during byte 4, then a fresh frame on the first tick
    set_reply(72'hFF_41_5A_0F_F0_00_00_00_00);
    frame_base = cmd_log.size();
    for (int i = 0; i < 3 * POLL_CNT && (cmd_log.size() - frame_base) < 5; i++) @(posedge clk);
    chk("reach_byte4", {31'h0, (cmd_log.size() - frame_base) >= 5}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    chk("midrst_send_req", {31'h0, bus.o_send_req}, 32'd0);
    chk("midrst_send_data", {24'h0, bus.o_send_data}, 32'h00);
    chk("midrst_pulses", {30'h0, data_valid, frame_err}, 32'd0);
    chk_outputs("midrst");
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    rel_cyc = cyc;
    set_reply(72'hFF_41_5A_FF_7F_00_00_00_00);
    do_frame("post_rst", 1'b0, 1'b0, 1'b0);
    chk("post_rst_first_req", prev_first - rel_cyc, POLL_CNT + 1);

    chk("send_req_single_cycle", wide_cnt, 32'd0);
    chk("valid_err_overlap", overlap_cnt, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
